// File: rtl/icmp_sched_pkg.sv
// Shared types and constants for the ICMP echo reply scheduler.
// Covers state and class encodings, the queued request layout and a saturating increment.
package icmp_sched_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ICMP_BUSY = 2'd1,
        UDP_BUSY  = 2'd2
    } sched_state_t;

    typedef enum logic {
        CLS_UDP  = 1'b0,
        CLS_ICMP = 1'b1
    } tx_class_t;

    localparam int ICMP_REQ_W = 32;

    typedef struct packed {
        logic [15:0] id;
        logic [15:0] seq;
    } icmp_req_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/icmp_echo_sched_if.sv
// Signal bundle between the echo scheduler and its surroundings: the RX parser,
// the ICMP reply generator, the UDP layer and the IP TX mux.
interface icmp_echo_sched_if #(
    parameter int FIFO_AW = 2
);
    logic               i_icmp_trigger;
    logic [15:0]        i_icmp_identifier;
    logic [15:0]        i_icmp_sequence;
    logic               o_icmp_tx_start;
    logic [15:0]        o_icmp_tx_id;
    logic [15:0]        o_icmp_tx_seq;
    logic               i_icmp_tx_done;
    logic               i_udp_req;
    logic               o_udp_grant;
    logic               i_udp_done;
    logic               o_ip_sel;
    logic [FIFO_AW:0]   o_fifo_level;
    logic [15:0]        o_drop_cnt;
    logic               o_timeout;

    modport slave (
        input  i_icmp_trigger, i_icmp_identifier, i_icmp_sequence, i_icmp_tx_done,
               i_udp_req, i_udp_done,
        output o_icmp_tx_start, o_icmp_tx_id, o_icmp_tx_seq, o_udp_grant, o_ip_sel,
               o_fifo_level, o_drop_cnt, o_timeout
    );

    modport master (
        output i_icmp_trigger, i_icmp_identifier, i_icmp_sequence, i_icmp_tx_done,
               i_udp_req, i_udp_done,
        input  o_icmp_tx_start, o_icmp_tx_id, o_icmp_tx_seq, o_udp_grant, o_ip_sel,
               o_fifo_level, o_drop_cnt, o_timeout
    );
endinterface

// File: rtl/icmp_req_fifo.sv
// Small synchronous queue of pending echo requests.
// A push on a full queue is accepted only when a pop happens in the same cycle.
module icmp_req_fifo
    import icmp_sched_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [ICMP_REQ_W-1:0] i_data,
    output logic [ICMP_REQ_W-1:0] o_head,
    output logic [AW:0]           o_level,
    output logic                  o_dropped
);
    logic [ICMP_REQ_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_level;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;

    assign w_full    = (r_level == (AW+1)'(DEPTH));
    assign w_empty   = (r_level == '0);
    assign w_pop     = i_pop & ~w_empty;
    assign w_push    = i_push & (~w_full | w_pop);
    assign o_dropped = i_push & ~w_push;
    assign o_head    = r_mem[r_rd_ptr];
    assign o_level   = r_level;

    // Storage carries no reset; only the pointers define what is valid.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            always_ff @(posedge i_clk) begin
                if (w_push && (r_wr_ptr == AW'(gi)))
                    r_mem[gi] <= i_data;
            end
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end
endmodule

// File: rtl/icmp_echo_sched.sv
// Arbitrates the IP TX path between queued ICMP echo replies and the UDP layer,
// packet by packet in round robin, with a stall timeout on each grant.
module icmp_echo_sched
    import icmp_sched_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int FIFO_AW     = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic               i_clk,
    input  logic               i_rst,
    icmp_echo_sched_if.slave   bus
);
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    sched_state_t          r_state, w_state_next;
    tx_class_t             r_last, w_last_next;
    logic [TMR_W-1:0]      r_timer, w_timer_next;
    logic                  r_start, w_start_next;
    logic                  r_timeout, w_timeout_next;
    logic                  r_grant, w_grant_next;
    logic                  r_ip_sel, w_ip_sel_next;
    logic [15:0]           r_id, w_id_next;
    logic [15:0]           r_seq, w_seq_next;
    logic [15:0]           r_drop;
    logic                  w_pop;
    logic                  w_dropped;
    logic [ICMP_REQ_W-1:0] w_head;
    icmp_req_t             w_head_req;
    logic [FIFO_AW:0]      w_level;

    icmp_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_push    (bus.i_icmp_trigger),
        .i_pop     (w_pop),
        .i_data    ({bus.i_icmp_identifier, bus.i_icmp_sequence}),
        .o_head    (w_head),
        .o_level   (w_level),
        .o_dropped (w_dropped)
    );

    assign w_head_req = icmp_req_t'(w_head);

    always_comb begin
        w_state_next   = r_state;
        w_last_next    = r_last;
        w_timer_next   = '0;
        w_start_next   = 1'b0;
        w_timeout_next = 1'b0;
        w_grant_next   = r_grant;
        w_ip_sel_next  = r_ip_sel;
        w_id_next      = r_id;
        w_seq_next     = r_seq;
        w_pop          = 1'b0;
        case (r_state)
            IDLE: begin
                // On contention, serve whichever class did not go last.
                if ((w_level != '0) && (!bus.i_udp_req || r_last == CLS_UDP)) begin
                    w_state_next  = ICMP_BUSY;
                    w_pop         = 1'b1;
                    w_start_next  = 1'b1;
                    w_id_next     = w_head_req.id;
                    w_seq_next    = w_head_req.seq;
                    w_ip_sel_next = 1'b1;
                    w_last_next   = CLS_ICMP;
                end else if (bus.i_udp_req) begin
                    w_state_next  = UDP_BUSY;
                    w_grant_next  = 1'b1;
                    w_ip_sel_next = 1'b0;
                    w_last_next   = CLS_UDP;
                end
            end
            ICMP_BUSY: begin
                if (bus.i_icmp_tx_done || r_timer == TMR_LAST) begin
                    w_state_next   = IDLE;
                    w_ip_sel_next  = 1'b0;
                    w_timeout_next = ~bus.i_icmp_tx_done;
                end else begin
                    w_timer_next = r_timer + TMR_W'(1);
                end
            end
            UDP_BUSY: begin
                if (bus.i_udp_done || r_timer == TMR_LAST) begin
                    w_state_next   = IDLE;
                    w_grant_next   = 1'b0;
                    w_timeout_next = ~bus.i_udp_done;
                end else begin
                    w_timer_next = r_timer + TMR_W'(1);
                end
            end
            default: begin
                w_state_next  = IDLE;
                w_grant_next  = 1'b0;
                w_ip_sel_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_last    <= CLS_UDP;
            r_timer   <= '0;
            r_start   <= 1'b0;
            r_timeout <= 1'b0;
            r_grant   <= 1'b0;
            r_ip_sel  <= 1'b0;
            r_id      <= '0;
            r_seq     <= '0;
            r_drop    <= '0;
        end else begin
            r_state   <= w_state_next;
            r_last    <= w_last_next;
            r_timer   <= w_timer_next;
            r_start   <= w_start_next;
            r_timeout <= w_timeout_next;
            r_grant   <= w_grant_next;
            r_ip_sel  <= w_ip_sel_next;
            r_id      <= w_id_next;
            r_seq     <= w_seq_next;
            if (w_dropped)
                r_drop <= sat_inc16(r_drop);
        end
    end

    assign bus.o_icmp_tx_start = r_start;
    assign bus.o_icmp_tx_id    = r_id;
    assign bus.o_icmp_tx_seq   = r_seq;
    assign bus.o_udp_grant     = r_grant;
    assign bus.o_ip_sel        = r_ip_sel;
    assign bus.o_fifo_level    = w_level;
    assign bus.o_drop_cnt      = r_drop;
    assign bus.o_timeout       = r_timeout;
endmodule

// File: tb/tb_icmp_echo_sched.sv
// Directed bench for the ICMP echo scheduler: latency, round robin, overflow,
// push/pop at full, grant timeout and asynchronous reset during a grant.
module tb_icmp_echo_sched;
    localparam int TO = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    icmp_echo_sched_if #(.FIFO_AW(2)) bus ();

    icmp_echo_sched #(
        .FIFO_DEPTH  (4),
        .FIFO_AW     (2),
        .TIMEOUT_CYC (TO)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic trig(input logic [15:0] id, input logic [15:0] seq);
        bus.i_icmp_trigger    = 1'b1;
        bus.i_icmp_identifier = id;
        bus.i_icmp_sequence   = seq;
        tick();
        bus.i_icmp_trigger    = 1'b0;
        $display("trigger id=%04h seq=%04h level=%0d drop=%0d", id, seq,
                 bus.o_fifo_level, bus.o_drop_cnt);
    endtask

    task automatic done_icmp();
        bus.i_icmp_tx_done = 1'b1;
        tick();
        bus.i_icmp_tx_done = 1'b0;
    endtask

    task automatic done_udp();
        bus.i_udp_done = 1'b1;
        tick();
        bus.i_udp_done = 1'b0;
    endtask

    // cls: 1 = ICMP owns the path, 0 = UDP, -1 = nothing granted within budget
    task automatic wait_grant(output int cls);
        cls = -1;
        for (int n = 0; n < 50; n++) begin
            if (bus.o_ip_sel) begin cls = 1; break; end
            if (bus.o_udp_grant) begin cls = 0; break; end
            tick();
        end
        $display("grant cls=%0d seq=%04h", cls, bus.o_icmp_tx_seq);
    endtask

    initial begin
        int cls;
        int n;
        int exp_cls [5] = '{1, 0, 1, 0, 1};
        int exp_seq [5] = '{16'h10, 0, 16'h11, 0, 16'h12};

        bus.i_icmp_trigger    = 1'b0;
        bus.i_icmp_identifier = '0;
        bus.i_icmp_sequence   = '0;
        bus.i_icmp_tx_done    = 1'b0;
        bus.i_udp_req         = 1'b0;
        bus.i_udp_done        = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_start",   bus.o_icmp_tx_start, 0);
        check("rst_grant",   bus.o_udp_grant, 0);
        check("rst_ip_sel",  bus.o_ip_sel, 0);
        check("rst_level",   bus.o_fifo_level, 0);
        check("rst_drop",    bus.o_drop_cnt, 0);
        check("rst_timeout", bus.o_timeout, 0);
        check("rst_id",      bus.o_icmp_tx_id, 0);

        // T1: single echo, start two edges after the trigger is launched
        trig(16'h1234, 16'h0001);
        check("t1_level_after_push", bus.o_fifo_level, 1);
        check("t1_no_early_start", bus.o_icmp_tx_start, 0);
        tick();
        check("t1_start", bus.o_icmp_tx_start, 1);
        check("t1_id", bus.o_icmp_tx_id, 16'h1234);
        check("t1_seq", bus.o_icmp_tx_seq, 16'h0001);
        check("t1_ip_sel", bus.o_ip_sel, 1);
        check("t1_level_popped", bus.o_fifo_level, 0);
        done_udp();
        check("t1_start_one_cycle", bus.o_icmp_tx_start, 0);
        check("t1_udp_done_ignored", bus.o_ip_sel, 1);
        done_icmp();
        check("t1_release_ip_sel", bus.o_ip_sel, 0);
        check("t1_release_level", bus.o_fifo_level, 0);

        // T2: round robin between three echoes and a persistent UDP request
        do_reset();
        trig(16'hA000, 16'h10);
        trig(16'hA001, 16'h11);
        bus.i_udp_req = 1'b1;
        trig(16'hA002, 16'h12);
        for (int i = 0; i < 5; i++) begin
            wait_grant(cls);
            check("t2_class", cls, exp_cls[i]);
            if (exp_cls[i] == 1) begin
                check("t2_seq", bus.o_icmp_tx_seq, exp_seq[i]);
                done_icmp();
            end else begin
                if (i == 3) bus.i_udp_req = 1'b0;
                done_udp();
            end
            check("t2_idle_gap", {bus.o_ip_sel, bus.o_udp_grant}, 0);
        end

        // T3: overflow, the sixth request is dropped
        do_reset();
        for (int s = 1; s <= 6; s++) trig(16'hB000, 16'(s));
        check("t3_level_full", bus.o_fifo_level, 4);
        check("t3_drop", bus.o_drop_cnt, 1);
        for (int s = 1; s <= 5; s++) begin
            wait_grant(cls);
            check("t3_class", cls, 1);
            check("t3_seq", bus.o_icmp_tx_seq, s);
            done_icmp();
        end
        tick(); tick(); tick();
        check("t3_drained_ip_sel", bus.o_ip_sel, 0);
        check("t3_drained_level", bus.o_fifo_level, 0);
        check("t3_drop_hold", bus.o_drop_cnt, 1);

        // T4: push coincident with pop at full
        do_reset();
        for (int s = 1; s <= 5; s++) trig(16'hC000, 16'(s));
        check("t4_level_pre", bus.o_fifo_level, 4);
        done_icmp();
        trig(16'hC000, 16'h6);
        check("t4_level", bus.o_fifo_level, 4);
        check("t4_drop", bus.o_drop_cnt, 0);
        check("t4_start", bus.o_icmp_tx_start, 1);
        check("t4_seq", bus.o_icmp_tx_seq, 2);

        // T5: grant timeout, then the next request is served and a late done ignored
        do_reset();
        trig(16'hD000, 16'h55);
        trig(16'hD001, 16'h56);
        n = 0;
        while (!bus.o_timeout && n < TO + 100) begin
            tick();
            n++;
        end
        $display("timeout after %0d cycles", n);
        check("t5_timeout_cycles", n, TO);
        check("t5_ip_sel_released", bus.o_ip_sel, 0);
        check("t5_level", bus.o_fifo_level, 1);
        done_icmp();
        check("t5_timeout_pulse", bus.o_timeout, 0);
        check("t5_next_start", bus.o_icmp_tx_start, 1);
        check("t5_next_seq", bus.o_icmp_tx_seq, 16'h56);
        tick();
        check("t5_late_done_ignored", bus.o_ip_sel, 1);

        // T6: asynchronous reset while UDP holds the path
        do_reset();
        bus.i_udp_req = 1'b1;
        tick();
        check("t6_grant", bus.o_udp_grant, 1);
        check("t6_ip_sel", bus.o_ip_sel, 0);
        for (int s = 1; s <= 5; s++) trig(16'hE000, 16'(s));
        check("t6_level", bus.o_fifo_level, 4);
        check("t6_drop", bus.o_drop_cnt, 1);
        bus.i_udp_req = 1'b0;
        tick();
        check("t6_grant_held", bus.o_udp_grant, 1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_grant", bus.o_udp_grant, 0);
        check("t6_rst_level", bus.o_fifo_level, 0);
        check("t6_rst_drop", bus.o_drop_cnt, 0);
        tick();
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
